alu_arbiter: RTL and testbench

Shares one 64-bit ALU datapath between two independent requesters, for example the main pipeline and an address-generation or debug unit.
- Each requester uses a valid/ready request channel.
- Arbitration is round-robin.
- Operands are registered, executed on the shared ALU for one cycle, and returned on a single response channel tagged with the requester id.
- The block sits between the requesters and the existing ALU module, which it instantiates.

---
 rtl/alu_arbiter_pkg.sv | 25 ++
 rtl/alu_arbiter_alu.sv | 33 +++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: datapath widths,
// ALU opcode encodings, FSM state encoding and an opcode-legality helper.
package alu_arbiter_pkg;

    localparam int unsigned ALU_DATA_W = 64;
    localparam int unsigned ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Encodings above PASS B are reserved and flagged as errors.
    function automatic logic op_supported(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_PASSB;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the arbiter.
// Ports:
//   a, b     operands
//   alu_op   opcode (ADD/SUB/AND/OR/PASS B; others produce zero)
//   zero     address == 0
//   address  result, add/sub wrap modulo 2^DATA_W
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OP_W   = ALU_OP_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   alu_op,
    output logic              zero,
    output logic [DATA_W-1:0] address
);

    always_comb begin
        address = '0;
        case (alu_op)
            ALU_ADD:   address = a + b;
            ALU_SUB:   address = a - b;
            ALU_AND:   address = a & b;
            ALU_OR:    address = a | b;
            ALU_PASSB: address = b;
            default:   address = '0;
        endcase
        zero = (address == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// A granted request is registered (IDLE), executed for one cycle (EXEC) and
// returned on a single response channel tagged with the requester id (RESP).
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/op          request channel of requester N (N = 0, 1)
//   resp_valid/ready                 response handshake
//   resp_id/result/zero/err          response payload
//   busy                             FSM is not in IDLE
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_err,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              rr_ptr_q;
    logic              id_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [OP_W-1:0]   op_q;

    logic              gnt_id;
    logic              accept;
    logic              in_idle;
    logic              alu_zero;
    logic [DATA_W-1:0] alu_result;

    // Grant: a lone requester wins; on contention rr_ptr picks the winner.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
        // Ready is gated by reset so it drops the moment reset is asserted.
        in_idle    = (state_q == ST_IDLE) && !reset;
        req0_ready = in_idle && req0_valid && !gnt_id;
        req1_ready = in_idle && req1_valid && gnt_id;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
            id_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
        end else if (accept) begin
            rr_ptr_q <= ~gnt_id;
            id_q     <= gnt_id;
            a_q      <= gnt_id ? req1_a  : req0_a;
            b_q      <= gnt_id ? req1_b  : req0_b;
            op_q     <= gnt_id ? req1_op : req0_op;
        end
    end

    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a       (a_q),
        .b       (b_q),
        .alu_op  (op_q),
        .zero    (alu_zero),
        .address (alu_result)
    );

    // Response registers load only at the end of EXEC and hold afterwards;
    // unsupported opcodes override the ALU output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            resp_id <= id_q;
            if (op_supported(op_q)) begin
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
                resp_err    <= 1'b0;
            end else begin
                resp_result <= '0;
                resp_zero   <= 1'b1;
                resp_err    <= 1'b1;
            end
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned W = ALU_DATA_W;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [2:0]   req1_op;
    logic         resp_valid, resp_ready, resp_id, resp_zero, resp_err, busy;
    logic [W-1:0] resp_result;

    typedef struct packed {
        logic         id;
        logic [W-1:0] result;
        logic         zero;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            3'b000:  e.result = a + b;
            3'b001:  e.result = a - b;
            3'b010:  e.result = a & b;
            3'b011:  e.result = a | b;
            3'b100:  e.result = b;
            default: begin
                e.result = '0;
                e.err    = 1'b1;
            end
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic start(input logic id, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (!id) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        sb.push_back(model(id, op, a, b));
    endtask

    task automatic check_resp();
        exp_t e;
        if (sb.size() == 0) begin
            fail_now("unexpected_response");
        end else begin
            e = sb.pop_front();
            check("resp_id", W'(resp_id), W'(e.id));
            check("resp_result", resp_result, e.result);
            check("resp_zero", W'(resp_zero), W'(e.zero));
            check("resp_err", W'(resp_err), W'(e.err));
        end
    endtask

    // Called just after a negedge; runs until all requests are served.
    task automatic drain();
        logic a0, a1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (sb.size() == 0 && !req0_valid && !req1_valid && !busy) return;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (resp_valid && resp_ready) check_resp();
            @(posedge clk);
            #1;
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            @(negedge clk);
        end
        fail_now("drain_timeout");
    endtask

    task automatic wait_resp_valid();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (resp_valid) return;
        end
        fail_now("resp_valid_timeout");
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp_valid", W'(resp_valid), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_resp_result", resp_result, '0);
        check("rst_resp_flags", W'({resp_id, resp_zero, resp_err}), '0);
        @(negedge clk);
        reset = 1'b0;

        // Contention from reset: req0 first, then req1.
        @(negedge clk);
        start(1'b0, ALU_SUB, 64'd9, 64'd9);
        start(1'b1, ALU_OR, 64'hF0, 64'h0F);
        #1;
        check("cont_ready0", W'(req0_ready), W'(1));
        check("cont_ready1", W'(req1_ready), W'(0));
        drain();
        // After serving req1 the pointer is back at req0.
        @(negedge clk);
        start(1'b0, ALU_ADD, 64'd1, 64'd2);
        start(1'b1, ALU_AND, 64'hFF, 64'h0F);
        #1;
        check("cont2_ready0", W'(req0_ready), W'(1));
        check("cont2_ready1", W'(req1_ready), W'(0));
        drain();

        // Single request latency.
        @(negedge clk);
        start(1'b0, ALU_ADD, 64'd5, 64'd7);
        #1;
        check("single_ready0", W'(req0_ready), W'(1));
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        #1;
        check("single_exec_valid", W'(resp_valid), W'(0));
        check("single_exec_busy", W'(busy), W'(1));
        @(negedge clk);
        #1;
        check("single_t2_valid", W'(resp_valid), W'(1));
        check("single_result", resp_result, 64'd12);
        drain();

        // Backpressure.
        @(negedge clk);
        resp_ready = 1'b0;
        start(1'b0, ALU_AND, 64'hF0F0, 64'hFF00);
        #1;
        check("bp_ready0", W'(req0_ready), W'(1));
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_resp_valid();
        start(1'b1, ALU_PASSB, 64'd0, 64'd77);
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", W'(resp_valid), W'(1));
            check("bp_result", resp_result, e.result);
            check("bp_readies", W'({req0_ready, req1_ready}), '0);
            check("bp_busy", W'(busy), W'(1));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check_resp();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_valid_drop", W'(resp_valid), W'(0));
        check("bp_next_ready1", W'(req1_ready), W'(1));
        drain();

        // Wrap, unsupported opcode, PASS B.
        @(negedge clk);
        start(1'b0, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        drain();
        @(negedge clk);
        start(1'b1, 3'b110, 64'd5, 64'd6);
        drain();
        @(negedge clk);
        start(1'b0, ALU_PASSB, 64'h1234, 64'hDEAD_BEEF);
        drain();

        // Reset in the middle of RESP.
        @(negedge clk);
        resp_ready = 1'b0;
        start(1'b0, ALU_OR, 64'd3, 64'd4);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_resp_valid();
        req1_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_valid", W'(resp_valid), W'(0));
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_readies", W'({req0_ready, req1_ready}), '0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 1'b1;
        start(1'b1, ALU_SUB, 64'd10, 64'd3);
        #1;
        check("postrst_ready1", W'(req1_ready), W'(1));
        check("postrst_ready0", W'(req0_ready), W'(0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
